// File: rtl/bcd_down_counter_3dig.sv
// Three-digit BCD down-counter with loadable start value, used as the pong countdown timer and lives counter.
// Digits are decremented independently with a borrow ripple, so out always holds valid BCD.
module bcd_down_counter_3dig #(
    parameter bit WRAP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load,
    input  logic [11:0] din,
    input  logic        en,
    output logic [11:0] out,
    output logic        zero,
    output logic        busy,
    output logic        done_tick,
    output logic        underflow,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [11:0] out_reg;
    logic        done_tick_reg;
    logic        underflow_reg;
    logic        load_err_reg;

    logic [11:0] din_sat;
    logic [11:0] dec_value;
    logic [2:0]  nib_sat;
    logic [2:0]  borrow;

    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [3:0] din_nib;
            logic [3:0] out_nib;

            assign din_nib = din[gi*4 +: 4];
            assign out_nib = out_reg[gi*4 +: 4];

            // Out-of-range load digits clamp to 9 rather than wrapping.
            assign nib_sat[gi]          = (din_nib > 4'd9);
            assign din_sat[gi*4 +: 4]   = nib_sat[gi] ? 4'd9 : din_nib;

            assign dec_value[gi*4 +: 4] = !borrow[gi]        ? out_nib :
                                          (out_nib == 4'd0)  ? 4'd9    :
                                                               out_nib - 4'd1;
            if (gi < 2) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (out_nib == 4'd0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_reg       <= 12'h000;
            done_tick_reg <= 1'b0;
            underflow_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            done_tick_reg <= 1'b0;
            underflow_reg <= 1'b0;
            load_err_reg  <= 1'b0;
            if (clr) begin
                state_reg <= IDLE;
                out_reg   <= 12'h000;
            end else if (load) begin
                out_reg      <= din_sat;
                load_err_reg <= |nib_sat;
                // Loading zero without wrap has nothing to count: park in DONE silently.
                state_reg    <= ((din_sat != 12'h000) || WRAP) ? RUN : DONE;
            end else if ((state_reg == RUN) && en) begin
                if (out_reg == 12'h000) begin
                    if (WRAP) begin
                        out_reg       <= 12'h999;
                        underflow_reg <= 1'b1;
                    end else begin
                        state_reg <= DONE;
                    end
                end else begin
                    out_reg <= dec_value;
                    if (!WRAP && (out_reg == 12'h001)) begin
                        state_reg     <= DONE;
                        done_tick_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign out       = out_reg;
    assign zero      = (out_reg == 12'h000);
    assign busy      = (state_reg == RUN);
    assign done_tick = done_tick_reg;
    assign underflow = underflow_reg;
    assign load_err  = load_err_reg;

endmodule

// File: tb/tb_bcd_down_counter_3dig.sv
// Scoreboard bench: drives a WRAP=0 and a WRAP=1 counter with identical stimulus and checks both every cycle.
module tb_bcd_down_counter_3dig;

    typedef struct {
        logic [11:0] out;
        logic        zero;
        logic        busy;
        logic        done_tick;
        logic        underflow;
        logic        load_err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, clr, load, en;
    logic [11:0] din;

    logic [11:0] out_a, out_b;
    logic        zero_a, busy_a, dt_a, uf_a, le_a;
    logic        zero_b, busy_b, dt_b, uf_b, le_b;

    exp_t q_a[$];
    exp_t q_b[$];
    string name_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bcd_down_counter_3dig #(.WRAP(1'b0)) u_nowrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en),
        .out(out_a), .zero(zero_a), .busy(busy_a), .done_tick(dt_a),
        .underflow(uf_a), .load_err(le_a)
    );

    bcd_down_counter_3dig #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en),
        .out(out_b), .zero(zero_b), .busy(busy_b), .done_tick(dt_b),
        .underflow(uf_b), .load_err(le_b)
    );

    function automatic exp_t mk(logic [11:0] o, logic b, logic dt, logic uf, logic le);
        exp_t e;
        e.out = o; e.zero = (o == 12'h000); e.busy = b;
        e.done_tick = dt; e.underflow = uf; e.load_err = le;
        return e;
    endfunction

    function automatic logic [11:0] bcd(int n);
        logic [3:0] h, t, u;
        h = 4'(n / 100); t = 4'((n / 10) % 10); u = 4'(n % 10);
        return {h, t, u};
    endfunction

    task automatic step(string nm, logic r, logic c, logic l, logic [11:0] d, logic e,
                        exp_t ea, exp_t eb);
        reset = r; clr = c; load = l; din = d; en = e;
        @(posedge clk);
        #1;
        q_a.push_back(ea);
        q_b.push_back(eb);
        name_q.push_back(nm);
    endtask

    task automatic check(string nm, string which, exp_t exp, logic [11:0] o, logic z,
                         logic b, logic dt, logic uf, logic le);
        vectors++;
        if (o !== exp.out || z !== exp.zero || b !== exp.busy || dt !== exp.done_tick ||
            uf !== exp.underflow || le !== exp.load_err) begin
            miscompares++;
            $display("FAIL %s/%s: got out=%h z=%b busy=%b dt=%b uf=%b le=%b, want out=%h z=%b busy=%b dt=%b uf=%b le=%b",
                     nm, which, o, z, b, dt, uf, le,
                     exp.out, exp.zero, exp.busy, exp.done_tick, exp.underflow, exp.load_err);
        end else begin
            $display("ok   %s/%s: out=%h z=%b busy=%b dt=%b uf=%b le=%b",
                     nm, which, o, z, b, dt, uf, le);
        end
    endtask

    // Monitor: one expected record per DUT per clock, consumed mid-cycle.
    always @(negedge clk) begin
        if (q_a.size() > 0 && q_b.size() > 0 && name_q.size() > 0) begin
            exp_t ea, eb;
            string nm;
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            nm = name_q.pop_front();
            check(nm, "w0", ea, out_a, zero_a, busy_a, dt_a, uf_a, le_a);
            check(nm, "w1", eb, out_b, zero_b, busy_b, dt_b, uf_b, le_b);
        end
    end

    initial begin
        reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; din = 12'h000;

        step("reset", 1, 0, 0, 12'h000, 0, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));
        step("idle_en", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));

        // Full countdown from 123 with en held.
        step("load123", 0, 0, 1, 12'h123, 1, mk(12'h123, 1, 0, 0, 0), mk(12'h123, 1, 0, 0, 0));
        for (int n = 122; n >= 0; n--) begin
            step("count", 0, 0, 0, 12'h000, 1,
                 mk(bcd(n), n != 0, n == 0, 0, 0), mk(bcd(n), 1, 0, 0, 0));
        end
        step("past0", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h999, 1, 0, 1, 0));
        step("past0b", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h998, 1, 0, 0, 0));
        step("clr", 0, 1, 0, 12'h000, 0, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));

        // Borrow chains and zero load.
        step("load100", 0, 0, 1, 12'h100, 0, mk(12'h100, 1, 0, 0, 0), mk(12'h100, 1, 0, 0, 0));
        step("dec100", 0, 0, 0, 12'h000, 1, mk(12'h099, 1, 0, 0, 0), mk(12'h099, 1, 0, 0, 0));
        step("load010", 0, 0, 1, 12'h010, 0, mk(12'h010, 1, 0, 0, 0), mk(12'h010, 1, 0, 0, 0));
        step("dec010", 0, 0, 0, 12'h000, 1, mk(12'h009, 1, 0, 0, 0), mk(12'h009, 1, 0, 0, 0));
        step("load000", 0, 0, 1, 12'h000, 0, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 1, 0, 0, 0));
        step("en_at0", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h999, 1, 0, 1, 0));
        step("clr2", 0, 1, 0, 12'h000, 0, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));

        // 001 -> 000 -> 999.
        step("load001", 0, 0, 1, 12'h001, 0, mk(12'h001, 1, 0, 0, 0), mk(12'h001, 1, 0, 0, 0));
        step("to000", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 1, 0, 0), mk(12'h000, 1, 0, 0, 0));
        step("to999", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h999, 1, 0, 1, 0));
        step("to998", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h998, 1, 0, 0, 0));

        // Digit sanitising.
        step("loadA3F", 0, 0, 1, 12'hA3F, 0, mk(12'h939, 1, 0, 0, 1), mk(12'h939, 1, 0, 0, 1));
        step("hold939", 0, 0, 0, 12'h000, 0, mk(12'h939, 1, 0, 0, 0), mk(12'h939, 1, 0, 0, 0));
        step("load999", 0, 0, 1, 12'h999, 0, mk(12'h999, 1, 0, 0, 0), mk(12'h999, 1, 0, 0, 0));
        step("loadF0A", 0, 0, 1, 12'hF0A, 0, mk(12'h909, 1, 0, 0, 1), mk(12'h909, 1, 0, 0, 1));

        // load beats en; pause with en low.
        step("load050", 0, 0, 1, 12'h050, 1, mk(12'h050, 1, 0, 0, 0), mk(12'h050, 1, 0, 0, 0));
        step("en1", 0, 0, 0, 12'h000, 1, mk(12'h049, 1, 0, 0, 0), mk(12'h049, 1, 0, 0, 0));
        step("en0", 0, 0, 0, 12'h000, 0, mk(12'h049, 1, 0, 0, 0), mk(12'h049, 1, 0, 0, 0));
        step("en1b", 0, 0, 0, 12'h000, 1, mk(12'h048, 1, 0, 0, 0), mk(12'h048, 1, 0, 0, 0));

        // clr mid-count, then en ignored in IDLE; clr beats load.
        step("load077", 0, 0, 1, 12'h077, 0, mk(12'h077, 1, 0, 0, 0), mk(12'h077, 1, 0, 0, 0));
        step("clr077", 0, 1, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));
        step("idle_en2", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));
        step("clr_load", 0, 1, 1, 12'h555, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));

        // Restart from DONE via load, then reset mid-count.
        step("load002", 0, 0, 1, 12'h002, 1, mk(12'h002, 1, 0, 0, 0), mk(12'h002, 1, 0, 0, 0));
        step("dec2", 0, 0, 0, 12'h000, 1, mk(12'h001, 1, 0, 0, 0), mk(12'h001, 1, 0, 0, 0));
        step("dec1", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 1, 0, 0), mk(12'h000, 1, 0, 0, 0));
        step("reload", 0, 0, 1, 12'h077, 1, mk(12'h077, 1, 0, 0, 0), mk(12'h077, 1, 0, 0, 0));
        step("dec77", 0, 0, 0, 12'h000, 1, mk(12'h076, 1, 0, 0, 0), mk(12'h076, 1, 0, 0, 0));
        step("rst_run", 1, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));
        step("post_rst", 0, 0, 0, 12'h000, 1, mk(12'h000, 0, 0, 0, 0), mk(12'h000, 0, 0, 0, 0));

        // Drain: the monitor must have consumed every record within two clocks.
        repeat (2) @(negedge clk);
        #1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d records left, want 0", q_a.size(), q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
